// File: rtl/tdf_stream_qin.sv
// tdf_stream_qin: per-channel input queue stage for TDF page modules.
// Each channel buffers {e, d} tokens in a DEPTH-entry FIFO, raises a registered
// back-pressure early enough to absorb SLACK in-flight tokens, and keeps sticky
// end-of-stream and overflow flags.
module tdf_stream_qin #(
  parameter int NCH   = 3,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NCH*WIDTH-1:0] in_d,
  input  logic [NCH-1:0]     in_e,
  input  logic [NCH-1:0]     in_v,
  output logic [NCH-1:0]     in_b,
  output logic [NCH*WIDTH-1:0] out_d,
  output logic [NCH-1:0]     out_e,
  output logic [NCH-1:0]     out_v,
  input  logic [NCH-1:0]     out_b,
  output logic [NCH-1:0]     eos_done,
  output logic [NCH-1:0]     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR  = (AW+1)'(DEPTH - SLACK);

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [WIDTH:0]  mem [DEPTH];
      logic [AW-1:0]   rd_ptr, wr_ptr;
      logic [AW:0]     count, count_next;
      logic            push, pop, full, accept;
      logic            b_q, ovf_q, eos_q;
      logic [WIDTH:0]  head;

      // Push/pop decisions; a pop at full frees the slot for a same-edge push.
      always_comb begin
        full       = (count == FULL);
        pop        = (count != '0) && !out_b[c];
        push       = in_v[c];
        accept     = push && (!full || pop);
        count_next = count;
        if (accept && !pop)
          count_next = count + (AW+1)'(1);
        else if (pop && !accept)
          count_next = count - (AW+1)'(1);
      end

      assign head = mem[rd_ptr];

      // Token storage; contents are not reset, outputs are gated by out_v instead.
      always_ff @(posedge clock) begin
        if (accept)
          mem[wr_ptr] <= {in_e[c], in_d[c*WIDTH +: WIDTH]};
      end

      // Pointers, occupancy, registered back-pressure and sticky flags.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
          b_q    <= 1'b0;
          ovf_q  <= 1'b0;
          eos_q  <= 1'b0;
        end else begin
          if (accept)
            wr_ptr <= wr_ptr + AW'(1);
          if (pop)
            rd_ptr <= rd_ptr + AW'(1);
          count <= count_next;
          b_q   <= (count_next >= THR);
          if (push && !accept)
            ovf_q <= 1'b1;
          if (pop && head[WIDTH])
            eos_q <= 1'b1;
        end
      end

      assign out_v[c]                 = (count != '0);
      assign out_d[c*WIDTH +: WIDTH]  = out_v[c] ? head[WIDTH-1:0] : '0;
      assign out_e[c]                 = out_v[c] ? head[WIDTH] : 1'b0;
      assign in_b[c]                  = b_q;
      assign ovf[c]                   = ovf_q;
      assign eos_done[c]              = eos_q;
    end
  endgenerate

endmodule
